// File: rtl/seq_shift_if.sv
// Request/response bundle for the multi-cycle shift unit.
// The master issues start/in/op/amt, and the slave returns busy/done/sout.
interface seq_shift_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [1:0]       op;
  logic [AMT_W-1:0] amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sout;

  modport master (output start, in, op, amt, input busy, done, sout);
  modport slave  (input start, in, op, amt, output busy, done, sout);
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: shifts the operand one bit position per clock.
// op encoding: 00 ROR, 01 LSL, 10 LSR, 11 ASR.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// SHIFT | one step per clock; exits after the step taken with count==1
// DONE  | one-cycle done pulse; a new start is accepted here as in IDLE
module seq_shift_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input logic        clk,
  input logic        reset,
  seq_shift_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_r;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] sout_r;
  logic             busy_r;
  logic             done_r;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s, input logic [1:0] o);
    case (o)
      2'b00:   step = {s[0], s[WIDTH-1:1]};
      2'b01:   step = {s[WIDTH-2:0], 1'b0};
      2'b10:   step = {1'b0, s[WIDTH-1:1]};
      default: step = {s[WIDTH-1], s[WIDTH-1:1]};
    endcase
  endfunction

  // Sequencer: the state, the operand/result register, and the registered busy/done flags.
  // busy/done are written from the next state, so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_r   <= 2'b00;
      count  <= '0;
      sout_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            sout_r <= bus.in;
            op_r   <= bus.op;
            count  <= bus.amt;
            if (bus.amt != '0) begin
              state  <= SHIFT;
              busy_r <= 1'b1;
            end else begin
              // A zero amount goes straight to the done pulse, and busy is never shown.
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          sout_r <= step(sout_r, op_r);
          count  <= count - AMT_W'(1);
          if (count == AMT_W'(1)) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sout = sout_r;

endmodule
